optical_rx_framer: RTL and testbench



---
 rtl/optical_rx_framer_pkg.sv | 27 ++
 rtl/optical_rx_framer_if.sv | 25 ++
 rtl/optical_rx_framer_rise_tick.sv | 22 ++
 rtl/optical_rx_framer.sv | 153 +++++++++++++++
 tb/tb_optical_rx_framer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/optical_rx_framer_pkg.sv
// Shared types and line constants for the optical receive framer.
// No logic or latency of its own; no backpressure.
package optrx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } optrx_state_e;

  localparam int OPT_DATA_BITS = 8;

  // Line polarity: light off while idle, on for the start bit, off for the stop bit.
  localparam logic OPT_IDLE_LVL  = 1'b0;
  localparam logic OPT_START_LVL = 1'b1;
  localparam logic OPT_STOP_LVL  = 1'b0;

  // LSB-first assembly: each new bit enters at the top and walks down.
  function automatic logic [OPT_DATA_BITS-1:0] opt_shift_in(
    input logic [OPT_DATA_BITS-1:0] cur,
    input logic                     bit_in
  );
    return {bit_in, cur[OPT_DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/optical_rx_framer_if.sv
// Received-byte bus from the framer to the byte consumer.
// Pulses are single-cycle and unconditioned; the consumer has no backpressure.
interface optical_rx_framer_if;
  import optrx_pkg::*;

  logic [OPT_DATA_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_frame_err;
  logic                     rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err,
    input rx_busy
  );

endinterface

// File: rtl/optical_rx_framer_rise_tick.sv
// Turns the divided sample clock into a one-cycle enable on its rising edge.
// Latency: tick is combinational against one register; no backpressure.
module rise_tick (
  input  logic clock,
  input  logic reset,
  input  logic new_clock,
  output logic tick
);

  logic nc_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      nc_d <= 1'b0;
    end else begin
      nc_d <= new_clock;
    end
  end

  assign tick = new_clock & ~nc_d;

endmodule

// File: rtl/optical_rx_framer.sv
// Start-bit aligned byte framer sampling the photodiode once per new_clock rise.
// Latency: pulse one cycle after the stop-sample tick; output is fire-and-forget, no backpressure.
module optical_rx_framer
  import optrx_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       new_clock,
  input  logic                       rx_in,
  optical_rx_framer_if.master        rx
);

  localparam int              CW        = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0]   HALF_LAST = CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [2:0]      IDX_LAST  = 3'(OPT_DATA_BITS - 1);

  generate
    if (SAMPLES_PER_BIT < 2 || (SAMPLES_PER_BIT % 2) != 0) begin : g_bad_spb
      $error("SAMPLES_PER_BIT must be even and at least 2");
    end
  endgenerate

  logic [1:0]               sync_q;
  logic                     rx_sync;
  logic                     tick;

  optrx_state_e             state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [OPT_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [OPT_DATA_BITS-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     busy_q, busy_d;

  // rx_in is asynchronous to clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_sync = sync_q[1];

  rise_tick u_rise_tick (
    .clock     (clock),
    .reset     (reset),
    .new_clock (new_clock),
    .tick      (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (rx_sync == OPT_START_LVL) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        // Re-check the start bit half a bit later; a short blip is dropped silently.
        START: begin
          if (cnt_q != HALF_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (rx_sync == OPT_START_LVL) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end

        DATA: begin
          if (cnt_q != BIT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            shreg_d = opt_shift_in(shreg_q, rx_sync);
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
            end
          end
        end

        STOP: begin
          if (cnt_q != BIT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rx_sync == OPT_STOP_LVL) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = ferr_q;
  assign rx.rx_busy      = busy_q;

endmodule

// File: tb/tb_optical_rx_framer.sv
// Bench for optical_rx_framer: line streams are decoded by a frame-level model and
// the DUT's pulses, bytes, timing and busy flag are compared against it.
module tb_optical_rx_framer;

  localparam int SPB     = 4;
  localparam int HALF    = SPB / 2;
  localparam int NC_HALF = 28;

  logic clock = 1'b0;
  logic reset;
  logic new_clock;
  logic rx_in;

  optical_rx_framer_if rx ();

  optical_rx_framer #(.SAMPLES_PER_BIT(SPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .new_clock (new_clock),
    .rx_in     (rx_in),
    .rx        (rx)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         tk;
    bit         err;
    logic [7:0] dat;
    longint     dt;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  bit         line_q[$];
  bit         busy_exp[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         cur_tick = 0;
  longint     rise_t = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pulse monitor: records every valid/error pulse with the tick it follows.
  always @(negedge clock) begin
    if (rx.rx_valid || rx.rx_frame_err) begin : mon
      ev_t e;
      check_val("valid_err_excl", 32'(rx.rx_valid & rx.rx_frame_err), 32'd0);
      check_val("pulse_width", 32'(prev_pulse), 32'd0);
      e.tk  = cur_tick;
      e.err = rx.rx_frame_err;
      e.dat = rx.rx_data;
      e.dt  = longint'($time) - rise_t;
      obs_q.push_back(e);
    end
    prev_pulse = rx.rx_valid | rx.rx_frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic add_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) line_q.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop_lvl);
    add_bits(1'b1, SPB);
    for (int i = 0; i < 8; i++) add_bits(b[i], SPB);
    add_bits(stop_lvl, SPB);
  endtask

  task automatic mark_busy(input int from, input int upto);
    for (int i = from; i <= upto; i++) busy_exp[i] = 1'b1;
  endtask

  // Frame-level decode of the per-tick line levels: where starts are found,
  // which ticks land mid-bit, and what the receiver must report and when.
  task automatic build_expect();
    int n;
    int pos;
    n   = line_q.size();
    pos = 0;
    busy_exp.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) busy_exp.push_back(1'b0);
    while (pos < n) begin
      if (line_q[pos]) begin : found
        int         t0;
        int         stp;
        logic [7:0] b;
        ev_t        e;
        t0 = pos;
        if (t0 + HALF >= n) begin
          mark_busy(t0, n - 1);
          pos = n;
        end else if (!line_q[t0 + HALF]) begin
          mark_busy(t0, t0 + HALF - 1);
          pos = t0 + HALF + 1;
        end else begin
          stp = t0 + HALF + 9 * SPB;
          if (stp >= n) begin
            mark_busy(t0, n - 1);
            pos = n;
          end else begin
            for (int k = 0; k < 8; k++) b[k] = line_q[t0 + HALF + SPB * (k + 1)];
            mark_busy(t0, stp - 1);
            e.tk  = stp;
            e.err = line_q[stp];
            e.dat = e.err ? last_good : b;
            e.dt  = 10;
            if (!e.err) last_good = b;
            exp_q.push_back(e);
            pos = stp + 1;
          end
        end
      end else begin
        pos++;
      end
    end
  endtask

  // Drives one line level per new_clock period; optional long freeze after a tick.
  task automatic run_stream(input int freeze_at);
    @(negedge clock);
    for (int k = 0; k < line_q.size(); k++) begin
      new_clock = 1'b0;
      rx_in     = line_q[k];
      repeat (NC_HALF) @(negedge clock);
      new_clock = 1'b1;
      cur_tick  = k;
      rise_t    = longint'($time);
      repeat (2) @(negedge clock);
      check_val("busy", 32'(rx.rx_busy), 32'(busy_exp[k]));
      repeat (NC_HALF - 2) @(negedge clock);
      if (k == freeze_at) begin
        repeat (500) @(negedge clock);
        check_val("frz_busy_mid", 32'(rx.rx_busy), 32'(busy_exp[k]));
        repeat (500) @(negedge clock);
        check_val("frz_busy_end", 32'(rx.rx_busy), 32'(busy_exp[k]));
      end
    end
  endtask

  task automatic compare_events(input string tag);
    int m;
    check_val({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_val({tag, "_tick"}, 32'(obs_q[i].tk), 32'(exp_q[i].tk));
      check_val({tag, "_err"}, 32'(obs_q[i].err), 32'(exp_q[i].err));
      check_val({tag, "_data"}, 32'(obs_q[i].dat), 32'(exp_q[i].dat));
      check_val({tag, "_lat"}, 32'(obs_q[i].dt), 32'(exp_q[i].dt));
    end
    obs_q.delete();
  endtask

  task automatic run_scn(input string tag, input int freeze_at);
    build_expect();
    run_stream(freeze_at);
    compare_events(tag);
    line_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    new_clock = 1'b0;
    rx_in     = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst_data", 32'(rx.rx_data), 32'd0);
    check_val("rst_valid", 32'(rx.rx_valid), 32'd0);
    check_val("rst_ferr", 32'(rx.rx_frame_err), 32'd0);
    check_val("rst_busy", 32'(rx.rx_busy), 32'd0);
    reset = 1'b0;

    add_bits(1'b0, 3);
    add_frame(8'hA5, 1'b0);
    add_bits(1'b0, 6);
    run_scn("a5", -1);
    check_val("hold_a5", 32'(rx.rx_data), 32'h0A5);

    add_bits(1'b0, 2);
    add_bits(1'b1, 1);
    add_bits(1'b0, 6);
    run_scn("glitch", -1);

    add_bits(1'b0, 2);
    add_frame(8'h3C, 1'b1);
    add_bits(1'b0, 6);
    run_scn("ferr", -1);
    check_val("hold_after_ferr", 32'(rx.rx_data), 32'h0A5);

    add_bits(1'b0, 2);
    add_frame(8'h00, 1'b0);
    add_frame(8'hFF, 1'b0);
    add_bits(1'b0, 6);
    run_scn("b2b", -1);

    // Partial frame cut off inside data bit 4, then reset.
    add_bits(1'b0, 2);
    add_frame(8'hC3, 1'b0);
    while (line_q.size() > 2 + 5 * SPB + 2) void'(line_q.pop_back());
    run_scn("rst_part", -1);
    new_clock = 1'b0;
    rx_in     = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    last_good = 8'h00;
    check_val("midrst_data", 32'(rx.rx_data), 32'd0);
    check_val("midrst_valid", 32'(rx.rx_valid), 32'd0);
    check_val("midrst_ferr", 32'(rx.rx_frame_err), 32'd0);
    check_val("midrst_busy", 32'(rx.rx_busy), 32'd0);

    add_bits(1'b0, 2);
    add_frame(8'h5A, 1'b0);
    add_bits(1'b0, 6);
    run_scn("post_rst", -1);

    add_bits(1'b0, 2);
    add_frame(8'h96, 1'b0);
    add_bits(1'b0, 6);
    run_scn("freeze", 2 + 15);

    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 5; f++) begin
        add_bits(1'b0, $urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) begin
          add_bits(1'b1, 1);
          add_bits(1'b0, 2);
        end
        add_frame(8'($urandom), ($urandom_range(0, 3) == 0));
      end
      add_bits(1'b0, 8);
      run_scn("rand", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
